// File: rtl/hit_scan_ctrl_pkg.sv
// Shared constants, location types and FSM state encoding for the w-mer hit-stage sequencer.
package hit_scan_ctrl_pkg;
    localparam int DATA_W   = 512;
    localparam int WMER_NT  = 11;
    localparam int WINDOWS  = DATA_W / 2 - WMER_NT + 1;
    localparam int SETTLE   = 2;
    localparam int SETTLE_W = 2;
    localparam int LOC_W    = 9;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 16;
    localparam int SHIFT_W  = 8;
    localparam int WORD_W   = ADDR_W - SHIFT_W;

    typedef logic [LOC_W-1:0]   qloc_t;
    typedef logic [ADDR_W-1:0]  dbloc_t;
    typedef logic [SHIFT_W-1:0] shift_t;
    typedef logic [WORD_W-1:0]  word_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QLOAD,
        S_DBWAIT,
        S_DBLOAD,
        S_SCAN,
        S_EXPAND,
        S_SHIFT,
        S_DONE
    } state_t;

    // Each database word holds 256 nucleotides, so the word index sits above an 8-bit offset.
    function automatic dbloc_t db_offset(input word_idx_t word_idx, input shift_t shift_cnt);
        return {word_idx, 8'b0} + dbloc_t'(shift_cnt);
    endfunction
endpackage

// File: rtl/hit_scan_ctrl_settle_timer.sv
// Settle timer: loads SETTLE, counts down to zero and holds; zero flags hit-stage outputs valid.
module hsc_settle_timer
    import hit_scan_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);
    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = SETTLE_W'(SETTLE);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/hit_scan_ctrl.sv
// Sequencer for the w-mer hit stage: loads the query, streams database words, walks every
// w-mer position and hands each seed hit to the ungapped-extension engine.
module hit_scan_ctrl
    import hit_scan_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] query_in,
    input  logic              query_valid,
    output logic              query_ready,
    input  logic [DATA_W-1:0] db_in,
    input  logic              db_valid,
    input  logic              db_last,
    output logic              db_ready,
    output logic [DATA_W-1:0] hs_query,
    output logic              hs_query_vld,
    output logic [DATA_W-1:0] hs_db,
    output logic              hs_db_vld,
    output logic              hs_load,
    output logic              hs_shift,
    output logic              hs_stop,
    input  logic              hs_hit,
    input  logic              hs_start_exp,
    input  logic [LOC_W-1:0]  hs_loc_q,
    input  logic              hs_end,
    output logic              ext_req,
    output logic [LOC_W-1:0]  ext_q_loc,
    output logic [ADDR_W-1:0] ext_db_loc,
    input  logic              ext_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count
);
    state_t             state_q,        state_d;
    logic [DATA_W-1:0]  hs_query_q,     hs_query_d;
    logic               hs_query_vld_q, hs_query_vld_d;
    logic [DATA_W-1:0]  hs_db_q,        hs_db_d;
    logic               db_last_q,      db_last_d;
    logic               hs_load_q,      hs_load_d;
    logic               hs_shift_q,     hs_shift_d;
    logic               hs_stop_q,      hs_stop_d;
    logic               ext_req_q,      ext_req_d;
    qloc_t              ext_q_loc_q,    ext_q_loc_d;
    dbloc_t             ext_db_loc_q,   ext_db_loc_d;
    word_idx_t          word_idx_q,     word_idx_d;
    shift_t             shift_cnt_q,    shift_cnt_d;
    logic [CNT_W-1:0]   hit_count_q,    hit_count_d;
    logic               settle_load;
    logic               settle_zero;

    hsc_settle_timer u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load),
        .zero (settle_zero)
    );

    always_comb begin
        state_d        = state_q;
        hs_query_d     = hs_query_q;
        hs_query_vld_d = 1'b0;
        hs_db_d        = hs_db_q;
        db_last_d      = db_last_q;
        hs_load_d      = 1'b0;
        hs_shift_d     = 1'b0;
        hs_stop_d      = 1'b0;
        ext_req_d      = ext_req_q;
        ext_q_loc_d    = ext_q_loc_q;
        ext_db_loc_d   = ext_db_loc_q;
        word_idx_d     = word_idx_q;
        shift_cnt_d    = shift_cnt_q;
        hit_count_d    = hit_count_q;
        settle_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hit_count_d = '0;
                    word_idx_d  = '0;
                    shift_cnt_d = '0;
                    state_d     = S_QLOAD;
                end
            end
            S_QLOAD: begin
                if (query_valid) begin
                    hs_query_d     = query_in;
                    hs_query_vld_d = 1'b1;
                    state_d        = S_DBWAIT;
                end
            end
            S_DBWAIT: begin
                if (db_valid) begin
                    hs_db_d   = db_in;
                    db_last_d = db_last;
                    state_d   = S_DBLOAD;
                end
            end
            S_DBLOAD: begin
                hs_load_d   = 1'b1;
                shift_cnt_d = '0;
                settle_load = 1'b1;
                state_d     = S_SCAN;
            end
            S_SCAN: begin
                // A selected hit outranks hs_end when both arrive together.
                if (settle_zero) begin
                    if (hs_start_exp) begin
                        ext_req_d    = 1'b1;
                        ext_q_loc_d  = hs_loc_q;
                        ext_db_loc_d = db_offset(word_idx_q, shift_cnt_q);
                        state_d      = S_EXPAND;
                    end else if (hs_end || !hs_hit) begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_EXPAND: begin
                if (ext_ack && ext_req_q) begin
                    ext_req_d   = 1'b0;
                    hs_stop_d   = 1'b1;
                    settle_load = 1'b1;
                    if (hit_count_q != '1) begin
                        hit_count_d = hit_count_q + 1'b1;
                    end
                    state_d = S_SCAN;
                end
            end
            S_SHIFT: begin
                if (shift_cnt_q == shift_t'(WINDOWS - 1)) begin
                    if (db_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = S_DBWAIT;
                    end
                end else begin
                    hs_shift_d  = 1'b1;
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    settle_load = 1'b1;
                    state_d     = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            hs_query_q     <= '0;
            hs_query_vld_q <= 1'b0;
            hs_db_q        <= '0;
            db_last_q      <= 1'b0;
            hs_load_q      <= 1'b0;
            hs_shift_q     <= 1'b0;
            hs_stop_q      <= 1'b0;
            ext_req_q      <= 1'b0;
            ext_q_loc_q    <= '0;
            ext_db_loc_q   <= '0;
            word_idx_q     <= '0;
            shift_cnt_q    <= '0;
            hit_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            hs_query_q     <= hs_query_d;
            hs_query_vld_q <= hs_query_vld_d;
            hs_db_q        <= hs_db_d;
            db_last_q      <= db_last_d;
            hs_load_q      <= hs_load_d;
            hs_shift_q     <= hs_shift_d;
            hs_stop_q      <= hs_stop_d;
            ext_req_q      <= ext_req_d;
            ext_q_loc_q    <= ext_q_loc_d;
            ext_db_loc_q   <= ext_db_loc_d;
            word_idx_q     <= word_idx_d;
            shift_cnt_q    <= shift_cnt_d;
            hit_count_q    <= hit_count_d;
        end
    end

    assign query_ready  = (state_q == S_QLOAD);
    assign db_ready     = (state_q == S_DBWAIT);
    assign hs_db_vld    = (state_q == S_SCAN) || (state_q == S_EXPAND) || (state_q == S_SHIFT);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign hs_query     = hs_query_q;
    assign hs_query_vld = hs_query_vld_q;
    assign hs_db        = hs_db_q;
    assign hs_load      = hs_load_q;
    assign hs_shift     = hs_shift_q;
    assign hs_stop      = hs_stop_q;
    assign ext_req      = ext_req_q;
    assign ext_q_loc    = ext_q_loc_q;
    assign ext_db_loc   = ext_db_loc_q;
    assign hit_count    = hit_count_q;
endmodule

// File: tb/tb_hit_scan_ctrl.sv
// Bench for hit_scan_ctrl: a hit-stage/extension-engine environment driven from a per-position
// hit table, with expected requests and pulse counts derived from that table.
module tb_hit_scan_ctrl;
    localparam int TB_WIN = 246;

    logic         clk = 1'b0;
    logic         rst, start, query_valid, query_ready, db_valid, db_last, db_ready;
    logic [511:0] query_in, db_in, hs_query, hs_db;
    logic         hs_query_vld, hs_db_vld, hs_load, hs_shift, hs_stop;
    logic         hs_hit, hs_start_exp, hs_end, ext_req, ext_ack, busy, done;
    logic [8:0]   hs_loc_q, ext_q_loc;
    logic [31:0]  ext_db_loc;
    logic [15:0]  hit_count;

    always #5 clk = ~clk;

    hit_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .query_in(query_in), .query_valid(query_valid), .query_ready(query_ready),
        .db_in(db_in), .db_valid(db_valid), .db_last(db_last), .db_ready(db_ready),
        .hs_query(hs_query), .hs_query_vld(hs_query_vld), .hs_db(hs_db), .hs_db_vld(hs_db_vld),
        .hs_load(hs_load), .hs_shift(hs_shift), .hs_stop(hs_stop),
        .hs_hit(hs_hit), .hs_start_exp(hs_start_exp), .hs_loc_q(hs_loc_q), .hs_end(hs_end),
        .ext_req(ext_req), .ext_q_loc(ext_q_loc), .ext_db_loc(ext_db_loc), .ext_ack(ext_ack),
        .busy(busy), .done(done), .hit_count(hit_count)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hit table: nh[word*256+pos] hits at that position, locations in lt[addr*4+k].
    int         nh[int];
    logic [8:0] lt[int];

    // Hit-stage environment: tracks the current position from the strobes it receives.
    int env_word, env_pos, env_k, env_busy;
    initial begin
        hs_hit = 0; hs_start_exp = 0; hs_end = 0; hs_loc_q = '0;
        env_word = -1; env_pos = 0; env_k = 0; env_busy = 0;
        forever begin
            int  addr;
            bit  pend;
            @(negedge clk);
            if (rst) begin
                hs_hit = 0; hs_start_exp = 0; hs_end = 0;
            end else begin
                if (hs_load) begin
                    env_word++; env_pos = 0; env_k = 0; env_busy = $urandom_range(0, 4);
                end else if (hs_shift) begin
                    env_pos++; env_k = 0; env_busy = $urandom_range(0, 4);
                end else if (hs_stop) begin
                    env_k++; env_busy = $urandom_range(0, 4);
                end
                addr = env_word * 256 + env_pos;
                pend = (env_word >= 0) && nh.exists(addr) && (env_k < nh[addr]);
                if (env_busy > 0) begin
                    env_busy--;
                    hs_hit = 1; hs_start_exp = 0; hs_end = 0;
                end else if (pend) begin
                    hs_hit = 1; hs_start_exp = 1;
                    hs_end = 1'($urandom_range(0, 1));
                    hs_loc_q = lt[addr * 4 + env_k];
                end else begin
                    hs_start_exp = 0;
                    hs_hit = 1'($urandom_range(0, 1));
                    hs_end = hs_hit ? 1'b1 : 1'($urandom_range(0, 1));
                    hs_loc_q = 9'($urandom);
                end
            end
        end
    end

    // Extension engine: acks after a random delay, with occasional stray acks.
    bit ack_en = 1;
    int ack_wait = 0;
    initial begin
        ext_ack = 0;
        forever begin
            @(negedge clk);
            if (ext_ack) ext_ack = 0;
            else if (ext_req && ack_en) begin
                if (ack_wait == 0) begin
                    ext_ack = 1; ack_wait = $urandom_range(0, 6);
                end else ack_wait--;
            end else if (!ext_req && $urandom_range(0, 15) == 0) ext_ack = 1;
        end
    end

    // Observer: strobe counts, protocol violations, request tuples.
    int n_load, n_shift, n_stop, n_done, n_viol;
    logic [40:0] obs_q[$];
    logic [40:0] exp_q[$];
    initial begin
        bit          prev_req, prev_strobe;
        logic [40:0] held;
        prev_req = 0; prev_strobe = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_load  += int'(hs_load);
                n_shift += int'(hs_shift);
                n_stop  += int'(hs_stop);
                n_done  += int'(done);
                if (int'(hs_load) + int'(hs_shift) + int'(hs_stop) > 1) n_viol++;
                if (prev_strobe && (hs_load || hs_shift || hs_stop)) n_viol++;
                if (ext_req && !prev_req) obs_q.push_back({ext_q_loc, ext_db_loc});
                if (ext_req && prev_req && {ext_q_loc, ext_db_loc} != held) n_viol++;
            end
            prev_strobe = hs_load || hs_shift || hs_stop;
            prev_req = ext_req;
            held = {ext_q_loc, ext_db_loc};
        end
    end

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic start_and_query();
        logic [511:0] q;
        env_word = -1;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < 50 && !query_ready; i++) @(negedge clk);
        check("query_ready", 64'(query_ready), 64'(1));
        q = rand_word();
        query_in = q; query_valid = 1;
        @(negedge clk); query_valid = 0;
        check("hs_query", 64'(hs_query === q), 64'(1));
        check("hs_query_vld", 64'(hs_query_vld), 64'(1));
    endtask

    task automatic feed_word(input bit last, input int bp_cycles);
        logic [511:0] w;
        int bad;
        int loads0;
        for (int i = 0; i < 5000 && !db_ready; i++) @(negedge clk);
        check("db_ready_wait", 64'(db_ready), 64'(1));
        if (bp_cycles > 0) begin
            bad = 0; loads0 = n_load;
            repeat (bp_cycles) begin
                @(negedge clk);
                if (db_ready !== 1'b1 || n_load != loads0) bad++;
            end
            check("backpressure", 64'(bad), 64'(0));
        end
        w = rand_word();
        db_in = w; db_last = last; db_valid = 1;
        @(negedge clk); db_valid = 0; db_last = 0;
        check("hs_db", 64'(hs_db === w), 64'(1));
    endtask

    task automatic run_search(input int nwords, input int bp_word, input int bp_cycles, input bit poke);
        int total, bad;
        logic [15:0] hc;
        exp_q.delete(); obs_q.delete(); total = 0;
        for (int w = 0; w < nwords; w++)
            for (int p = 0; p < TB_WIN; p++) begin
                int a = w * 256 + p;
                if (nh.exists(a))
                    for (int k = 0; k < nh[a]; k++) begin
                        exp_q.push_back({lt[a * 4 + k], 32'(a)});
                        total++;
                    end
            end
        n_load = 0; n_shift = 0; n_stop = 0; n_done = 0; n_viol = 0;
        start_and_query();
        for (int w = 0; w < nwords; w++) begin
            feed_word(w == nwords - 1, (w == bp_word) ? bp_cycles : 0);
            if (poke && w == 0) begin
                for (int i = 0; i < 5000 && hit_count == 0; i++) @(negedge clk);
                hc = hit_count;
                @(negedge clk); start = 1;
                @(negedge clk); start = 0;
                check("start_busy_kept", 64'(hit_count >= hc && hc != 0), 64'(1));
                check("start_busy_noq", 64'(query_ready), 64'(0));
            end
        end
        for (int i = 0; i < 5000 && n_done == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("done_pulses", 64'(n_done), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
        check("n_load", 64'(n_load), 64'(nwords));
        check("n_shift", 64'(n_shift), 64'(nwords * (TB_WIN - 1)));
        check("n_stop", 64'(n_stop), 64'(total));
        check("hit_count", 64'(hit_count), 64'(total));
        check("strobe_proto", 64'(n_viol), 64'(0));
        check("n_req", 64'(obs_q.size()), 64'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) bad++;
        check("req_tuples", 64'(bad), 64'(0));
        $display("search words=%0d hits=%0d reqs=%0d hit_count=%0d", nwords, total, obs_q.size(), hit_count);
    endtask

    initial begin
        rst = 1; start = 0; query_valid = 0; db_valid = 0; db_last = 0;
        query_in = '0; db_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'({query_ready, db_ready}), 64'(0));
        check("rst_ext", 64'({ext_req, ext_q_loc, ext_db_loc}), 64'(0));
        check("rst_hitcnt", 64'(hit_count), 64'(0));
        check("rst_hs", 64'({hs_db_vld, hs_load, hs_shift, hs_stop, hs_query_vld}), 64'(0));
        rst = 0;
        @(negedge clk);

        // No-hit path.
        nh.delete(); lt.delete();
        run_search(1, -1, 0, 0);

        // Single hit at word 2, position 7, query offset 40.
        nh.delete(); lt.delete();
        nh[2 * 256 + 7] = 1; lt[(2 * 256 + 7) * 4] = 9'd40;
        ack_wait = 5;
        run_search(3, -1, 0, 0);
        check("single_tuple", 64'(obs_q.size() > 0 ? obs_q[0] : 41'd0), 64'({9'd40, 32'd519}));

        // Back-to-back hits on one position, with 20 cycles of database backpressure.
        nh.delete(); lt.delete();
        nh[100] = 3;
        for (int k = 0; k < 3; k++) lt[400 + k] = 9'($urandom);
        run_search(1, 0, 20, 0);

        // Randomized hit tables; the second search also pokes start while busy.
        for (int t = 0; t < 3; t++) begin
            int nw = $urandom_range(1, 3);
            nh.delete(); lt.delete();
            for (int w = 0; w < nw; w++)
                for (int p = 0; p < TB_WIN; p++)
                    if ($urandom_range(0, 39) == 0) begin
                        int a = w * 256 + p;
                        nh[a] = $urandom_range(1, 2);
                        for (int k = 0; k < 2; k++) lt[a * 4 + k] = 9'($urandom);
                    end
            if (t == 1) begin
                nh[3] = 1; lt[12] = 9'($urandom);
            end
            run_search(nw, $urandom_range(0, nw - 1), $urandom_range(0, 3), t == 1);
        end

        // Reset while an extension request is outstanding.
        nh.delete(); lt.delete();
        nh[5] = 1; lt[20] = 9'd77;
        ack_en = 0; n_done = 0;
        start_and_query();
        feed_word(1'b1, 0);
        for (int i = 0; i < 2000 && !ext_req; i++) @(negedge clk);
        check("midexp_req", 64'(ext_req), 64'(1));
        rst = 1;
        @(negedge clk);
        check("midexp_busy", 64'(busy), 64'(0));
        check("midexp_ext", 64'({ext_req, ext_q_loc, ext_db_loc}), 64'(0));
        check("midexp_hit", 64'(hit_count), 64'(0));
        check("midexp_hs", 64'({hs_db_vld, hs_load, hs_shift, hs_stop, hs_query_vld, done}), 64'(0));
        check("midexp_db", 64'(hs_db === '0 && hs_query === '0), 64'(1));
        rst = 0; ack_en = 1;
        repeat (5) @(negedge clk);
        check("midexp_nodone", 64'(n_done), 64'(0));

        // Recovery after the abandoned search.
        nh.delete(); lt.delete();
        run_search(1, -1, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
